dbus_wb_bridge: RTL and testbench

//  Data-side bus bridge directly downstream of the CPU core's MEM-stage RAM port
//  (ram_ce/we/sel/addr/data). Converts each single-cycle request into one Wishbone

---
 rtl/dbus_wb_bridge.sv | 148 ++++++++++++++
 tb/tb_dbus_wb_bridge.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dbus_wb_bridge.sv
// rtl/dbus_wb_bridge.sv - MEM-stage RAM port to single-access Wishbone classic master bridge
// Optional BUSY timeout abort is built in when DBUS_TIMEOUT_EN is defined.
module dbus_wb_bridge #(
  parameter int STALL_BIT      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_FOR_STALL
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] rd_buf;
  logic        start;
  logic        done;
  logic        timeout;
  logic        stall_mem;
  logic        stall_unused;

  assign stall_mem    = stall_i[STALL_BIT];
  assign stall_unused = ^stall_i;

`ifdef DBUS_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Fires in the TIMEOUT_CYCLES-th BUSY cycle without ack; the counter stops there, so it never wraps.
  assign timeout = (state == BUSY) && !wb_ack_i && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != BUSY) begin
      tmo_cnt <= '0;
    end else if (!wb_ack_i && !timeout) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= timeout && !flush_i;
    end
  end
`else
  assign timeout   = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // stallreq_o must stay independent of stall_i to avoid a combinational loop through ctrl.
  always_comb begin
    state_next = state;
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    start      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          start      = 1'b1;
          stallreq_o = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_next = IDLE;
        end else if (wb_ack_i || timeout) begin
          done = 1'b1;
          if (!wb_we_o && !timeout) begin
            cpu_data_o = wb_dat_i;
          end
          state_next = stall_mem ? WAIT_FOR_STALL : IDLE;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      WAIT_FOR_STALL: begin
        if (!wb_we_o && !flush_i) begin
          cpu_data_o = rd_buf;
        end
        if (flush_i || !stall_mem) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      rd_buf   <= '0;
    end else begin
      if (start) begin
        wb_adr_o <= cpu_addr_i;
        wb_dat_o <= cpu_data_i;
        wb_we_o  <= cpu_we_i;
        wb_sel_o <= cpu_sel_i;
        wb_stb_o <= 1'b1;
        wb_cyc_o <= 1'b1;
      end else if (state == BUSY && state_next != BUSY) begin
        wb_stb_o <= 1'b0;
        wb_cyc_o <= 1'b0;
      end
      if (done && (timeout || !wb_we_o)) begin
        rd_buf <= timeout ? 32'd0 : wb_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_dbus_wb_bridge.sv
// tb/tb_dbus_wb_bridge.sv - scoreboard bench for dbus_wb_bridge, per-cycle expectations
// The timeout scenario is included when DBUS_TIMEOUT_EN is defined.
module tb_dbus_wb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic        bus_err_o;

  always #5 clk = ~clk;

  dbus_wb_bridge #(.STALL_BIT(4), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
    .bus_err_o(bus_err_o)
  );

  typedef struct packed {
    logic        full;
    logic        sr;
    logic [31:0] data;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t  q_exp[$];
  string q_name[$];
  int    errors = 0;
  int    checks = 0;

  logic        e_we;
  logic [3:0]  e_sel;
  logic [31:0] e_adr;
  logic [31:0] e_dat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic sr, input logic [31:0] d,
                     input logic cyc, input logic err, input logic full);
    exp_t e;
    e.full = full; e.sr = sr; e.data = d; e.cyc = cyc; e.we = e_we;
    e.sel = e_sel; e.adr = e_adr; e.dat = e_dat; e.err = err;
    q_exp.push_back(e);
    q_name.push_back(name);
  endtask

  task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat);
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_sel_i = sel; cpu_addr_i = adr; cpu_data_i = dat;
    e_we = we; e_sel = sel; e_adr = adr; e_dat = dat;
  endtask

  // Monitor: compares the oldest expectation against the DUT mid-cycle.
  initial begin
    exp_t  e;
    string n;
    logic  bad;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        n = q_name.pop_front();
        checks++;
        bad = (stallreq_o !== e.sr) || (cpu_data_o !== e.data) || (wb_cyc_o !== e.cyc) ||
              (wb_stb_o !== e.cyc) || (bus_err_o !== e.err);
        if (e.cyc || e.full) begin
          bad = bad || (wb_we_o !== e.we) || (wb_sel_o !== e.sel) ||
                (wb_adr_o !== e.adr) || (wb_dat_o !== e.dat);
        end
        if (bad) begin
          errors++;
          $display("FAIL %s: got sr=%b data=%h cyc=%b stb=%b err=%b we=%b sel=%h adr=%h dat=%h; expected sr=%b data=%h cyc=stb=%b err=%b we=%b sel=%h adr=%h dat=%h",
                   n, stallreq_o, cpu_data_o, wb_cyc_o, wb_stb_o, bus_err_o, wb_we_o, wb_sel_o,
                   wb_adr_o, wb_dat_o, e.sr, e.data, e.cyc, e.err, e.we, e.sel, e.adr, e.dat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall_i = '0; flush_i = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    cpu_sel_i = '0; cpu_addr_i = '0; cpu_data_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0;
    e_we = 1'b0; e_sel = '0; e_adr = '0; e_dat = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset", 0, 0, 0, 0, 1); tick();

    // Load, ack in 2nd BUSY cycle; stall_i activity must not affect stallreq_o.
    issue(0, 4'hF, 32'h0000_0100, 32'h0);
    chk("t1_req", 1, 0, 0, 0, 0); tick();
    cpu_ce_i = 0; stall_i = 6'b011111;
    chk("t1_busy1", 1, 0, 1, 0, 0); tick();
    stall_i = 0; wb_ack_i = 1; wb_dat_i = 32'hDEADBEEF;
    chk("t1_ack", 0, 32'hDEADBEEF, 1, 0, 0); tick();
    wb_ack_i = 0; wb_dat_i = 0;
    chk("t1_idle", 0, 0, 0, 0, 0); tick();

    // Store acked in 1st BUSY cycle: no data returned.
    issue(1, 4'b0011, 32'h10, 32'h1234_5678);
    chk("t2_req", 1, 0, 0, 0, 0); tick();
    cpu_ce_i = 0; wb_ack_i = 1; wb_dat_i = 32'hAAAA_5555;
    chk("t2_ack", 0, 0, 1, 0, 0); tick();
    wb_ack_i = 0; wb_dat_i = 0;
    chk("t2_idle", 0, 0, 0, 0, 0); tick();

    // Load acked while MEM is stalled; held request must be ignored.
    issue(0, 4'hF, 32'h200, 32'h0);
    chk("t3_req", 1, 0, 0, 0, 0); tick();
    cpu_addr_i = 32'h300; wb_ack_i = 1; wb_dat_i = 32'hCAFE_F00D; stall_i = 6'b010000;
    chk("t3_ack", 0, 32'hCAFE_F00D, 1, 0, 0); tick();
    wb_ack_i = 0; wb_dat_i = 32'h0BAD_BAD0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_wait", 0, 32'hCAFE_F00D, 0, 0, 0); tick();
    end
    cpu_ce_i = 0; stall_i = 0;
    chk("t3_release", 0, 32'hCAFE_F00D, 0, 0, 0); tick();
    chk("t3_idle", 0, 0, 0, 0, 0); tick();

`ifdef DBUS_TIMEOUT_EN
    // No ack: abort in the 4th BUSY cycle, rd_buf cleared, one-cycle error pulse.
    issue(0, 4'hF, 32'h600, 32'h0);
    chk("t6_req", 1, 0, 0, 0, 0); tick();
    cpu_ce_i = 0; stall_i = 6'b010000;
    for (int i = 0; i < 3; i++) begin
      chk("t6_busy", 1, 0, 1, 0, 0); tick();
    end
    chk("t6_timeout", 0, 0, 1, 0, 0); tick();
    chk("t6_err", 0, 0, 0, 1, 0); tick();
    stall_i = 0;
    chk("t6_wait", 0, 0, 0, 0, 0); tick();
    chk("t6_idle", 0, 0, 0, 0, 0); tick();
`endif

    // Flush in 2nd BUSY cycle, ack arrives one cycle late.
    issue(0, 4'hF, 32'h400, 32'h0);
    chk("t4_req", 1, 0, 0, 0, 0); tick();
    cpu_ce_i = 0;
    chk("t4_busy1", 1, 0, 1, 0, 0); tick();
    flush_i = 1;
    chk("t4_flush", 0, 0, 1, 0, 0); tick();
    flush_i = 0; wb_ack_i = 1; wb_dat_i = 32'h1111_1111;
    chk("t4_late_ack", 0, 0, 0, 0, 0); tick();
    wb_ack_i = 0; wb_dat_i = 0;
    chk("t4_idle", 0, 0, 0, 0, 0); tick();

    // Flush coincident with ack: data discarded, no WAIT_FOR_STALL.
    issue(0, 4'hF, 32'h440, 32'h0);
    chk("t4b_req", 1, 0, 0, 0, 0); tick();
    cpu_ce_i = 0; wb_ack_i = 1; flush_i = 1; wb_dat_i = 32'h2222_2222; stall_i = 6'b010000;
    chk("t4b_flush_ack", 0, 0, 1, 0, 0); tick();
    wb_ack_i = 0; flush_i = 0; wb_dat_i = 0;
    chk("t4b_idle", 0, 0, 0, 0, 0); tick();
    stall_i = 0;

    // Flush with a request in IDLE: request dropped.
    cpu_ce_i = 1; cpu_addr_i = 32'h480; flush_i = 1;
    chk("t4c_flush_req", 0, 0, 0, 0, 0); tick();
    cpu_ce_i = 0; flush_i = 0;
    chk("t4c_no_cycle", 0, 0, 0, 0, 0); tick();

    // Reset during BUSY drops the cycle; ack afterwards is ignored.
    issue(0, 4'b1100, 32'h500, 32'h0);
    chk("t5_req", 1, 0, 0, 0, 0); tick();
    cpu_ce_i = 0; rst = 1;
    chk("t5_rst_busy", 1, 0, 1, 0, 0); tick();
    rst = 0; e_we = 0; e_sel = 0; e_adr = 0; e_dat = 0;
    wb_ack_i = 1; wb_dat_i = 32'h3333_3333;
    chk("t5_after_rst", 0, 0, 0, 0, 1); tick();
    wb_ack_i = 0; wb_dat_i = 0;
    chk("t5_idle", 0, 0, 0, 0, 1); tick();

    @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
